// File: rtl/cpu_flags_pkg.sv
// Shared condition-code definitions for the flags unit and the decode/branch unit.
// Flags are always packed {N,Z,C,V}; cond_eval is the single source of truth for branch decoding.
package cpu_flags_pkg;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n;
        logic z;
        logic c;
        logic v;
        logic res;
        n   = flags[FLG_N];
        z   = flags[FLG_Z];
        c   = flags[FLG_C];
        v   = flags[FLG_V];
        res = 1'b0;
        case (cond)
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = c;
            COND_CC: res = ~c;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = c & ~z;
            COND_LS: res = ~c | z;
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = z | (n != v);
            COND_AL: res = 1'b1;
            COND_NV: res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/flag_stack.sv
// LIFO of saved flag sets for interrupt entry/exit, with full/empty status and an
// illegal-operation pulse. Illegal operations leave count and contents untouched.
module flag_stack
    import cpu_flags_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int PTR_W       = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [3:0] i_push_data,
    output logic [3:0] o_pop_data,
    output logic       o_pop_ok,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_err
);

    localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(STACK_DEPTH);

    logic [PTR_W-1:0] r_count;
    logic [3:0]       r_mem [STACK_DEPTH];
    logic             r_err;

    logic             w_full;
    logic             w_empty;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_illegal;
    logic [PTR_W-1:0] w_top;
    logic [3:0]       w_pop_data;

    assign w_full    = (r_count == DEPTH_CNT);
    assign w_empty   = (r_count == '0);
    assign w_push_ok = i_push & ~i_pop & ~w_full;
    assign w_pop_ok  = i_pop & ~i_push & ~w_empty;
    assign w_illegal = (i_push | i_pop) & ~w_push_ok & ~w_pop_ok;
    assign w_top     = r_count - 1'b1;

    // Read mux over the top entry; compared by value so the pointer width never has to match the array.
    always_comb begin
        w_pop_data = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (w_top == PTR_W'(i)) begin
                w_pop_data = r_mem[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_illegal;
            if (w_push_ok) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage carries no reset: entries above count are never observed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (w_push_ok && (r_count == PTR_W'(i))) begin
                r_mem[i] <= i_push_data;
            end
        end
    end

    assign o_pop_data = w_pop_data;
    assign o_pop_ok   = w_pop_ok;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_err      = r_err;

endmodule

// File: rtl/status_flags_unit.sv
// Flags register, masked flag write, registered branch-condition evaluation and flag save stack.
// Define FLAG_BYPASS_EN to evaluate conditions against the forwarded next-flags value.
module status_flags_unit
    import cpu_flags_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int PTR_W       = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       flag_we,
    input  logic [3:0] flag_mask,
    input  logic [3:0] cond,
    input  logic       cond_valid,
    output logic       take,
    output logic       take_valid,
    input  logic       push,
    input  logic       pop,
    output logic [3:0] flags_q,
    output logic       stack_full,
    output logic       stack_empty,
    output logic       stack_err
);

    logic [3:0] r_flags;
    logic       r_take;
    logic       r_take_valid;

    logic [3:0] w_alu;
    logic [3:0] w_merged;
    logic [3:0] w_next_flags;
    logic [3:0] w_eval_flags;
    logic [3:0] w_pop_data;
    logic       w_pop_ok;

    flag_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .PTR_W       (PTR_W)
    ) u_flag_stack (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (push),
        .i_pop       (pop),
        .i_push_data (r_flags),
        .o_pop_data  (w_pop_data),
        .o_pop_ok    (w_pop_ok),
        .o_full      (stack_full),
        .o_empty     (stack_empty),
        .o_err       (stack_err)
    );

    // A legal pop overrides any flag write issued in the same cycle.
    always_comb begin
        w_alu        = '0;
        w_alu[FLG_N] = alu_n;
        w_alu[FLG_Z] = alu_z;
        w_alu[FLG_C] = alu_c;
        w_alu[FLG_V] = alu_v;
        w_merged     = (r_flags & ~flag_mask) | (w_alu & flag_mask);
        w_next_flags = r_flags;
        if (w_pop_ok) begin
            w_next_flags = w_pop_data;
        end else if (flag_we) begin
            w_next_flags = w_merged;
        end
    end

`ifdef FLAG_BYPASS_EN
    assign w_eval_flags = w_next_flags;
`else
    assign w_eval_flags = r_flags;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags      <= '0;
            r_take       <= 1'b0;
            r_take_valid <= 1'b0;
        end else begin
            r_flags      <= w_next_flags;
            r_take_valid <= cond_valid;
            if (cond_valid) begin
                r_take <= cond_eval(cond, w_eval_flags);
            end
        end
    end

    assign flags_q    = r_flags;
    assign take       = r_take;
    assign take_valid = r_take_valid;

endmodule

// File: tb/tb_status_flags_unit.sv
// Self-checking bench for status_flags_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the flags, stack and branch result.
module tb_status_flags_unit;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alu_c, alu_v, alu_n, alu_z;
    logic       flag_we;
    logic [3:0] flag_mask;
    logic [3:0] cond;
    logic       cond_valid;
    logic       take, take_valid;
    logic       push, pop;
    logic [3:0] flags_q;
    logic       stack_full, stack_empty, stack_err;

    int checks = 0;
    int errors = 0;

    logic [3:0] m_flags;
    logic [3:0] m_stack [$];
    logic       m_take;
    logic       m_tv;
    logic       m_err;

    status_flags_unit #(.STACK_DEPTH(DEPTH), .PTR_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_c       (alu_c),
        .alu_v       (alu_v),
        .alu_n       (alu_n),
        .alu_z       (alu_z),
        .flag_we     (flag_we),
        .flag_mask   (flag_mask),
        .cond        (cond),
        .cond_valid  (cond_valid),
        .take        (take),
        .take_valid  (take_valid),
        .push        (push),
        .pop         (pop),
        .flags_q     (flags_q),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model_reset();
        m_flags = 4'h0;
        m_stack.delete();
        m_take  = 1'b0;
        m_tv    = 1'b0;
        m_err   = 1'b0;
    endfunction

    // Drives one cycle of inputs, advances the model, and returns 1 time unit after the edge.
    task automatic applyStimulus(input logic [3:0] alu_nzcv, input logic we, input logic [3:0] mask,
                                 input logic [3:0] cc, input logic cv, input logic p, input logic q);
        logic [3:0] pre;
        logic [3:0] nxt;
        logic       pok;
        logic       qok;
        {alu_n, alu_z, alu_c, alu_v} = alu_nzcv;
        flag_we    = we;
        flag_mask  = mask;
        cond       = cc;
        cond_valid = cv;
        push       = p;
        pop        = q;
        pre = m_flags;
        nxt = m_flags;
        pok = p && !q && (m_stack.size() < DEPTH);
        qok = q && !p && (m_stack.size() > 0);
        if (qok) begin
            nxt = m_stack.pop_back();
        end else if (we) begin
            for (int i = 0; i < 4; i++) if (mask[i]) nxt[i] = alu_nzcv[i];
        end
        if (pok) m_stack.push_back(pre);
        m_err = (p || q) && !pok && !qok;
        m_tv  = cv;
`ifdef FLAG_BYPASS_EN
        if (cv) m_take = ref_cond(cc, nxt);
`else
        if (cv) m_take = ref_cond(cc, pre);
`endif
        m_flags = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {alu_n, alu_z, alu_c, alu_v} = 4'h0;
        flag_we = 0; flag_mask = 0; cond = 0; cond_valid = 0; push = 0; pop = 0;
        model_reset();
        #12;
        checks++; if (flags_q !== 4'h0) begin errors++; $display("[TB] FAIL reset_flags got=%h exp=0", flags_q); end
        checks++; if (take_valid !== 1'b0 || take !== 1'b0) begin errors++; $display("[TB] FAIL reset_take got=%b/%b exp=0/0", take_valid, take); end
        checks++; if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_stack empty=%b full=%b exp=1/0", stack_empty, stack_full); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%b exp=0", stack_err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_logic_eq();
        applyStimulus(4'b0100, 1, 4'hF, 4'd0, 0, 0, 0);
        checks++; if (flags_q !== 4'b0100) begin errors++; $display("[TB] FAIL eq_write got=%b exp=0100", flags_q); end
        applyStimulus(4'h0, 0, 4'h0, 4'd0, 1, 0, 0);
        checks++; if (take_valid !== 1'b1 || take !== 1'b1) begin errors++; $display("[TB] FAIL eq_take got=%b/%b exp=1/1", take_valid, take); end
        applyStimulus(4'h0, 0, 4'h0, 4'd1, 1, 0, 0);
        checks++; if (take_valid !== 1'b1 || take !== 1'b0) begin errors++; $display("[TB] FAIL ne_take got=%b/%b exp=1/0", take_valid, take); end
        applyStimulus(4'h0, 0, 4'h0, 4'd0, 0, 0, 0);
        checks++; if (take_valid !== 1'b0 || take !== 1'b0) begin errors++; $display("[TB] FAIL take_hold got=%b/%b exp=0/0", take_valid, take); end
    endtask

    task automatic test_signed_compare();
        logic [3:0] ccs [6];
        logic       exps [6];
        ccs = '{4'd10, 4'd11, 4'd14, 4'd15, 4'd13, 4'd12};
        exps = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        applyStimulus(4'b1000, 1, 4'hF, 4'd0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            if (i == 4) applyStimulus(4'b1100, 1, 4'hF, 4'd0, 0, 0, 0);
            applyStimulus(4'h0, 0, 4'h0, ccs[i], 1, 0, 0);
            checks++;
            if (take_valid !== 1'b1 || take !== exps[i]) begin
                errors++;
                $display("[TB] FAIL signed_cond%0d got=%b/%b exp=1/%b", ccs[i], take_valid, take, exps[i]);
            end
        end
    endtask

    task automatic test_masked_write();
        applyStimulus(4'hF, 1, 4'hF, 4'd0, 0, 0, 0);
        applyStimulus(4'h0, 1, 4'b0010, 4'd0, 0, 0, 0);
        checks++; if (flags_q !== 4'b1101) begin errors++; $display("[TB] FAIL masked_write got=%b exp=1101", flags_q); end
    endtask

    task automatic test_stack();
        logic [3:0] vals [4];
        vals = '{4'h3, 4'h5, 4'hA, 4'hC};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vals[i], 1, 4'hF, 4'd0, 0, 0, 0);
            applyStimulus(4'h0, 0, 4'h0, 4'd0, 0, 1, 0);
        end
        checks++; if (stack_full !== 1'b1 || stack_err !== 1'b0) begin errors++; $display("[TB] FAIL stack_full got=%b err=%b exp=1/0", stack_full, stack_err); end
        applyStimulus(4'hF, 1, 4'hF, 4'd0, 0, 1, 0);
        checks++; if (stack_err !== 1'b1 || stack_full !== 1'b1 || flags_q !== 4'hF) begin errors++; $display("[TB] FAIL overflow err=%b full=%b flags=%h exp=1/1/f", stack_err, stack_full, flags_q); end
        applyStimulus(4'h0, 0, 4'h0, 4'd0, 0, 0, 0);
        checks++; if (stack_err !== 1'b0) begin errors++; $display("[TB] FAIL err_pulse got=%b exp=0", stack_err); end
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(4'h0, 0, 4'h0, 4'd0, 0, 0, 1);
            checks++;
            if (flags_q !== vals[i]) begin errors++; $display("[TB] FAIL pop%0d got=%h exp=%h", i, flags_q, vals[i]); end
        end
        checks++; if (stack_empty !== 1'b1) begin errors++; $display("[TB] FAIL stack_empty got=%b exp=1", stack_empty); end
        applyStimulus(4'h0, 0, 4'h0, 4'd0, 0, 0, 1);
        checks++; if (stack_err !== 1'b1 || flags_q !== 4'h3 || stack_empty !== 1'b1) begin errors++; $display("[TB] FAIL underflow err=%b flags=%h empty=%b exp=1/3/1", stack_err, flags_q, stack_empty); end
    endtask

    task automatic test_simultaneous();
        applyStimulus(4'hF, 1, 4'hF, 4'd0, 0, 0, 0);
        applyStimulus(4'h0, 0, 4'h0, 4'd0, 0, 1, 0);
        applyStimulus(4'h0, 0, 4'h0, 4'd0, 0, 1, 1);
        checks++; if (stack_err !== 1'b1 || stack_empty !== 1'b0 || stack_full !== 1'b0) begin errors++; $display("[TB] FAIL push_pop err=%b empty=%b full=%b exp=1/0/0", stack_err, stack_empty, stack_full); end
        applyStimulus(4'h0, 1, 4'hF, 4'd0, 0, 0, 1);
        checks++; if (flags_q !== 4'hF || stack_empty !== 1'b1) begin errors++; $display("[TB] FAIL pop_we flags=%h empty=%b exp=f/1", flags_q, stack_empty); end
        applyStimulus(4'h6, 1, 4'hF, 4'd0, 0, 1, 0);
        checks++; if (flags_q !== 4'h6) begin errors++; $display("[TB] FAIL push_we flags=%h exp=6", flags_q); end
        applyStimulus(4'h0, 0, 4'h0, 4'd0, 0, 0, 1);
        checks++; if (flags_q !== 4'hF) begin errors++; $display("[TB] FAIL push_we_saved got=%h exp=f", flags_q); end
    endtask

    task automatic test_random();
        logic p, q;
        for (int n = 0; n < 400; n++) begin
            p = ($urandom_range(0, 3) == 0);
            q = ($urandom_range(0, 3) == 0);
            applyStimulus(4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), p, q);
            checks++; if (flags_q !== m_flags) begin errors++; $display("[TB] FAIL rnd%0d_flags got=%h exp=%h", n, flags_q, m_flags); end
            checks++; if (take_valid !== m_tv || take !== m_take) begin errors++; $display("[TB] FAIL rnd%0d_take got=%b/%b exp=%b/%b", n, take_valid, take, m_tv, m_take); end
            checks++; if (stack_err !== m_err) begin errors++; $display("[TB] FAIL rnd%0d_err got=%b exp=%b", n, stack_err, m_err); end
            checks++;
            if (stack_full !== (m_stack.size() == DEPTH) || stack_empty !== (m_stack.size() == 0)) begin
                errors++;
                $display("[TB] FAIL rnd%0d_level full=%b empty=%b exp_count=%0d", n, stack_full, stack_empty, m_stack.size());
            end
        end
    endtask

    task automatic test_async_reset();
        applyStimulus(4'b1010, 1, 4'hF, 4'd14, 1, 0, 0);
        applyStimulus(4'h0, 0, 4'h0, 4'd14, 1, 1, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (take_valid !== 1'b0 || take !== 1'b0) begin errors++; $display("[TB] FAIL async_take got=%b/%b exp=0/0", take_valid, take); end
        checks++; if (stack_empty !== 1'b1 || flags_q !== 4'h0) begin errors++; $display("[TB] FAIL async_state empty=%b flags=%h exp=1/0", stack_empty, flags_q); end
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'h0, 0, 4'h0, 4'd0, 0, 0, 1);
        checks++; if (stack_err !== 1'b1 || flags_q !== 4'h0) begin errors++; $display("[TB] FAIL async_discard err=%b flags=%h exp=1/0", stack_err, flags_q); end
    endtask

    initial begin
        test_reset();
        test_logic_eq();
        test_signed_compare();
        test_masked_write();
        test_stack();
        test_simultaneous();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
